// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Signed operands are divided as magnitudes and the signs are applied in a
// final FIX cycle. The FIX cycle is also the done cycle, and a new start is
// accepted in it so back-to-back operations lose no cycles.
module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // acc holds the partial remainder magnitude; dq starts as the dividend
    // magnitude and has quotient bits shifted in from the bottom.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sgn_q, sgn_d;
    logic             sd_q, sd_d;
    logic             sv_q, sv_d;
    logic             zero_q, zero_d;

    // Result registers: hold the last completed result between done pulses.
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             rv_q, rv_d;

    logic             accept;
    logic             dd_neg, dv_neg;
    logic [WIDTH-1:0] dd_mag, dv_mag;
    logic [WIDTH:0]   shifted, trial;
    logic             q_bit;
    logic             q_neg, r_neg;
    logic [WIDTH-1:0] fix_quot, fix_rem;

    // A start is taken in IDLE or in the done (FIX) cycle; cancel always wins.
    assign accept = start && !cancel && (state_q != S_BUSY);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_BUSY;
            S_BUSY: begin
                if (cancel)             state_d = S_IDLE;
                else if (cnt_q == '0)   state_d = S_FIX;
            end
            S_FIX:  state_d = accept ? S_BUSY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; during the done cycle the freshly sign-fixed result is
    // presented directly so a cancel in FIX leaves the held result untouched.
    always_comb begin
        busy         = (state_q == S_BUSY);
        done         = (state_q == S_FIX) && !cancel;
        result_valid = done || rv_q;
        quotient     = done ? fix_quot : quotient_q;
        remainder    = done ? fix_rem  : remainder_q;
        div_by_zero  = done ? zero_q   : dbz_q;
    end

    // Operand magnitudes. |MIN_INT| = 2^(WIDTH-1) still fits unsigned in
    // WIDTH bits, so the wrapped two's-complement negation is exact.
    always_comb begin
        dd_neg = is_signed && dividend[WIDTH-1];
        dv_neg = is_signed && divisor[WIDTH-1];
        dd_mag = dd_neg ? (~dividend + 1'b1) : dividend;
        dv_mag = dv_neg ? (~divisor + 1'b1) : divisor;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only when it does not borrow.
    always_comb begin
        shifted = {acc_q, dq_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        q_bit   = !trial[WIDTH];
    end

    // Sign fix-up: quotient negative only for differing signs and nonzero
    // magnitude, remainder follows the dividend. Divide by zero forces an
    // all-ones quotient; the remainder naturally equals the raw dividend.
    always_comb begin
        q_neg    = sgn_q && (sd_q != sv_q) && (dq_q != '0);
        r_neg    = sgn_q && sd_q;
        fix_quot = zero_q ? '1 : (q_neg ? (~dq_q + 1'b1) : dq_q);
        fix_rem  = r_neg ? (~acc_q + 1'b1) : acc_q;
    end

    // Datapath next values: load on accepted start, iterate while busy.
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        dq_d   = dq_q;
        dvs_d  = dvs_q;
        sgn_d  = sgn_q;
        sd_d   = sd_q;
        sv_d   = sv_q;
        zero_d = zero_q;
        if (accept) begin
            cnt_d  = CW'(WIDTH - 1);
            acc_d  = '0;
            dq_d   = dd_mag;
            dvs_d  = dv_mag;
            sgn_d  = is_signed;
            sd_d   = dd_neg;
            sv_d   = dv_neg;
            zero_d = (divisor == '0);
        end else if ((state_q == S_BUSY) && !cancel) begin
            cnt_d = cnt_q - CW'(1);
            acc_d = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            dq_d  = {dq_q[WIDTH-2:0], q_bit};
        end
    end

    // Result register next values: captured on done, validity dropped on a
    // new accepted start or a cancel of an in-flight operation.
    always_comb begin
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        rv_d        = rv_q;
        if (done) begin
            quotient_d  = fix_quot;
            remainder_d = fix_rem;
            dbz_d       = zero_q;
            rv_d        = 1'b1;
        end
        if (accept || (cancel && (state_q != S_IDLE))) begin
            rv_d = 1'b0;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            sgn_q       <= 1'b0;
            sd_q        <= 1'b0;
            sv_q        <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            rv_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            dq_q        <= dq_d;
            dvs_q       <= dvs_d;
            sgn_q       <= sgn_d;
            sd_q        <= sd_d;
            sv_q        <= sv_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            rv_q        <= rv_d;
        end
    end

endmodule
